// File: rtl/mem_port_arbiter_if.sv
// Processor/memory bundle shared by the unified-memory arbiter.
// MEM_PORT_ARBITER_PERF_EN adds the i/d stall counters.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0]   i_stall_cnt;
  logic [31:0]   d_stall_cnt;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output i_stall_cnt, d_stall_cnt
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  i_stall_cnt, d_stall_cnt
  );
`else
  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D arbiter for a single-ported unified memory.
// Optional stall counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t        state;
  logic          last_d;
  logic          own_d;
  logic [3:0]    cnt;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          can_gnt;
  logic          gnt_i;
  logic          gnt_d;
  logic          rd_gnt;
  logic [AW-1:0] addr_mux;

  // RESP arbitrates like IDLE so back-to-back reads lose no cycle.
  always_comb begin
    can_gnt = reset && (state != WAIT);
    gnt_d   = can_gnt && bus.d_req
              && (!bus.i_req || !last_d);
    gnt_i   = can_gnt && bus.i_req && !gnt_d;
    rd_gnt  = gnt_i || (gnt_d && !bus.d_we);
  end

  always_comb begin
    addr_mux = '0;
    unique case (1'b1)
      gnt_d:   addr_mux = bus.d_addr;
      gnt_i:   addr_mux = bus.i_addr;
      default: addr_mux = '0;
    endcase
  end

  assign bus.i_ready  = gnt_i;
  assign bus.d_ready  = gnt_d;
  assign bus.m_en     = gnt_i || gnt_d;
  assign bus.m_we     = gnt_d && bus.d_we;
  assign bus.m_addr   = addr_mux;
  assign bus.m_wdata  = reset ? bus.d_wdata : '0;

  assign bus.i_rvalid = (state == RESP) && !own_d;
  assign bus.d_rvalid = (state == RESP) && own_d;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      own_d     <= 1'b0;
      cnt       <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (gnt_i || gnt_d) begin
        last_d <= gnt_d;
      end
      unique case (state)
        WAIT: begin
          if (cnt == '0) begin
            if (own_d) d_rdata_q <= bus.m_rdata;
            else       i_rdata_q <= bus.m_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (rd_gnt) begin
            state <= WAIT;
            cnt   <= LAT_M1;
            own_d <= gnt_d;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] i_stall_q;
  logic [31:0] d_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_stall_q <= '0;
      d_stall_q <= '0;
    end else begin
      if (bus.i_req && !gnt_i && (i_stall_q != '1)) begin
        i_stall_q <= i_stall_q + 32'd1;
      end
      if (bus.d_req && !gnt_d && (d_stall_q != '1)) begin
        d_stall_q <= d_stall_q + 32'd1;
      end
    end
  end

  assign bus.i_stall_cnt = i_stall_q;
  assign bus.d_stall_cnt = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a LATENCY=2 memory model.
// Covers MEM_PORT_ARBITER_PERF_EN counters when the macro is defined.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] A   = 32'h40;
  localparam logic [31:0] B   = 32'h54;
  localparam logic [31:0] W40 = 32'h2002_0005;
  localparam logic [31:0] W54 = 32'h1111_0054;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:63];
  logic [31:0] stg [0:LAT-1];

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h1000_0000 | k;
      mem[A[7:2]] <= W40;
      mem[B[7:2]] <= W54;
    end else if (bus.m_en && bus.m_we) begin
      mem[bus.m_addr[7:2]] <= bus.m_wdata;
    end
    stg[0] <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr[7:2]] : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
  end

  assign bus.m_rdata = stg[LAT-1];

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        irdy;
    logic        drdy;
    logic        men;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        irv;
    logic        drv;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    input logic ireq, input logic [31:0] iaddr,
    input logic dreq, input logic dwe,
    input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic irdy, input logic drdy,
    input logic men, input logic mwe,
    input logic [31:0] maddr, input logic [31:0] mwdata,
    input logic irv, input logic drv,
    input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.ireq = ireq;   v.iaddr = iaddr;
    v.dreq = dreq;   v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata;
    v.irdy = irdy;   v.drdy = drdy;
    v.men = men;     v.mwe = mwe;
    v.maddr = maddr; v.mwdata = mwdata;
    v.irv = irv;     v.drv = drv;
    v.ird = ird;     v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".i_ready"},  32'(bus.i_ready),  32'd0);
    chk({tag, ".d_ready"},  32'(bus.d_ready),  32'd0);
    chk({tag, ".m_en"},     32'(bus.m_en),     32'd0);
    chk({tag, ".m_we"},     32'(bus.m_we),     32'd0);
    chk({tag, ".m_addr"},   bus.m_addr,        32'd0);
    chk({tag, ".m_wdata"},  bus.m_wdata,       32'd0);
    chk({tag, ".i_rvalid"}, 32'(bus.i_rvalid), 32'd0);
    chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
    chk({tag, ".i_rdata"},  bus.i_rdata,       32'd0);
    chk({tag, ".d_rdata"},  bus.d_rdata,       32'd0);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk({tag, ".i_stall"},  bus.i_stall_cnt,   32'd0);
    chk({tag, ".d_stall"},  bus.d_stall_cnt,   32'd0);
`endif
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwdata);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // contention, write, late-drop and tie-after-drop sequences
    tbl[0]  = mk(1,A,1,0,B,0,   0,1,1,0,B,0, 0,0, 0,0);
    tbl[1]  = mk(1,A,1,0,B,0,   0,0,0,0,0,0, 0,0, 0,0);
    tbl[2]  = mk(1,A,1,0,B,0,   0,0,0,0,0,0, 0,0, 0,0);
    tbl[3]  = mk(1,A,1,0,B,0,   1,0,1,0,A,0, 0,1, 0,W54);
    tbl[4]  = mk(1,A,1,0,B,0,   0,0,0,0,0,0, 0,0, 0,W54);
    tbl[5]  = mk(1,A,1,0,B,0,   0,0,0,0,0,0, 0,0, 0,W54);
    tbl[6]  = mk(1,A,1,0,B,0,   0,1,1,0,B,0, 1,0, W40,W54);
    tbl[7]  = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, W40,W54);
    tbl[8]  = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, W40,W54);
    tbl[9]  = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,1, W40,W54);
    tbl[10] = mk(0,0,1,1,B,7,   0,1,1,1,B,7, 0,0, W40,W54);
    tbl[11] = mk(1,B,0,0,0,0,   1,0,1,0,B,0, 0,0, W40,W54);
    tbl[12] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, W40,W54);
    tbl[13] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, W40,W54);
    tbl[14] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 1,0, 7,W54);
    tbl[15] = mk(0,0,1,0,A,0,   0,1,1,0,A,0, 0,0, 7,W54);
    tbl[16] = mk(1,A,0,0,0,0,   0,0,0,0,0,0, 0,0, 7,W54);
    tbl[17] = mk(1,A,0,0,0,0,   0,0,0,0,0,0, 0,0, 7,W54);
    tbl[18] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,1, 7,W40);
    tbl[19] = mk(1,A,1,0,B,0,   1,0,1,0,A,0, 0,0, 7,W40);
    tbl[20] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, 7,W40);
    tbl[21] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 0,0, 7,W40);
    tbl[22] = mk(0,0,0,0,0,0,   0,0,0,0,0,0, 1,0, W40,W40);

    // reset held with both requesters active: everything must stay 0
    reset = 1'b0;
    drive(1, A, 1, 1, B, 32'h5A5A_5A5A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    next_cycle();
    reset = 1'b1;

    for (int r = 0; r < 23; r++) begin
      drive(tbl[r].ireq, tbl[r].iaddr, tbl[r].dreq,
            tbl[r].dwe, tbl[r].daddr, tbl[r].dwdata);
      @(negedge clk);
      chk($sformatf("r%0d.i_ready", r),  32'(bus.i_ready),  32'(tbl[r].irdy));
      chk($sformatf("r%0d.d_ready", r),  32'(bus.d_ready),  32'(tbl[r].drdy));
      chk($sformatf("r%0d.m_en", r),     32'(bus.m_en),     32'(tbl[r].men));
      chk($sformatf("r%0d.m_we", r),     32'(bus.m_we),     32'(tbl[r].mwe));
      chk($sformatf("r%0d.i_rvalid", r), 32'(bus.i_rvalid), 32'(tbl[r].irv));
      chk($sformatf("r%0d.d_rvalid", r), 32'(bus.d_rvalid), 32'(tbl[r].drv));
      chk($sformatf("r%0d.i_rdata", r),  bus.i_rdata,       tbl[r].ird);
      chk($sformatf("r%0d.d_rdata", r),  bus.d_rdata,       tbl[r].drd);
      if (tbl[r].men) begin
        chk($sformatf("r%0d.m_addr", r),  bus.m_addr,  tbl[r].maddr);
        chk($sformatf("r%0d.m_wdata", r), bus.m_wdata, tbl[r].mwdata);
      end
`ifdef MEM_PORT_ARBITER_PERF_EN
      if (r == 3) begin
        chk("perf.i_stall_at_grant", bus.i_stall_cnt, 32'd3);
        chk("perf.d_stall_at_grant", bus.d_stall_cnt, 32'd2);
      end
`endif
      next_cycle();
    end

    // reset pulse during WAIT discards the pending fetch return
    drive(1, B, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr.grant.i_ready", 32'(bus.i_ready), 32'd1);
    chk("mr.grant.m_addr",  bus.m_addr,       B);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("mr.rst");
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mr.post%0d.i_rvalid", k), 32'(bus.i_rvalid), 32'd0);
      chk($sformatf("mr.post%0d.d_rvalid", k), 32'(bus.d_rvalid), 32'd0);
      next_cycle();
    end

    drive(1, A, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr.rd.i_ready", 32'(bus.i_ready), 32'd1);
    chk("mr.rd.m_en",    32'(bus.m_en),    32'd1);
    chk("mr.rd.m_addr",  bus.m_addr,       A);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("mr.rd.t%0d.i_rvalid", k), 32'(bus.i_rvalid),
          (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("mr.rd.t%0d.d_rvalid", k), 32'(bus.d_rvalid), 32'd0);
      if (k == 3) chk("mr.rd.i_rdata", bus.i_rdata, W40);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, synchronous, unified instruction/data memory between the processor's fetch port (I) and load/store port (D).
- Sits between the processor and the memory, for the multicycle core variant where imem and dmem are merged into one array.
- Round-robin arbitration, valid/ready request handshake, fixed-latency read return, one outstanding access at a time.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LATENCY, 2, memory read latency in cycles, legal range 1..15: m_rdata is valid LATENCY cycles after the issue cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous and active-low.
- i_req  in  1  fetch read request.
- i_addr  in  AW  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse: i_rdata is valid.
- i_rdata  out  DW  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  write data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: d_rdata is valid.
- d_rdata  out  DW  data read data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.

Behaviour:
- Reset state while reset=0: FSM=IDLE, last_grant=I, latency counter=0.
  - i_rdata and d_rdata registers cleared to 0.
  - All outputs forced to 0, including the combinational ready, m_en and m_we outputs.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no requests: no outputs asserted.
- IDLE, requests present: grant one requester combinationally.
  - Only one requesting: grant it.
  - Both requesting: grant the one not in last_grant. After reset D therefore wins the first tie.
- Grant cycle T: granted x_ready=1, m_en=1, m_addr = granted address.
  - m_we = d_we when D is granted, 0 when I is granted.
  - m_wdata = d_wdata.
  - last_grant is updated.
- Write (D, d_we=1): completes in cycle T. No d_rvalid is produced; FSM stays IDLE, so a new grant is possible at T+1.
- Read: FSM goes to WAIT with counter = LATENCY-1.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 0 (cycle T+LATENCY), m_rdata is captured into the granted x_rdata register and the FSM goes to RESP.
- RESP (cycle T+LATENCY+1): granted x_rvalid=1 for exactly one cycle.
  - RESP behaves as IDLE for arbitration, so a new grant is allowed in the same cycle.
  - Read-to-read issue spacing under continuous demand: LATENCY+1 cycles.
- x_rdata holds its value until the next read return to that port.
- m_en=0 in WAIT. m_addr and m_wdata are don't-care whenever m_en=0.
- Requester rules:
  - Hold req, addr, we and wdata stable until ready is seen.
  - Dropping req before ready is legal; no access is issued and arbitration state is unchanged.
- Continuous contention: grants strictly alternate D, I, D, I...
- Reset asserted mid-operation: FSM returns to IDLE immediately and the pending rvalid is discarded. After reset release, no spurious rvalid appears.
- LATENCY=1: WAIT lasts one cycle; capture happens at T+1, rvalid at T+2.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined: adds two outputs, i_stall_cnt (out, 32) and d_stall_cnt (out, 32).
  - Each increments in every cycle where its req=1 and ready=0.
  - Each saturates at 0xFFFFFFFF.
  - Both clear to 0 on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY=2, i_req at addr 0x40 in cycle T, memory word 0x20020005 -> i_ready=1, m_en=1, m_addr=0x40 at T; i_rvalid=1 with i_rdata=0x20020005 at T+3 only.
- After reset, i_req and d_req (read 0x54) both asserted and held -> D granted first, I granted in D's rvalid cycle, then D again; grant order D, I, D with a spacing of 3 cycles.
- d_req with d_we=1, d_addr=0x54, d_wdata=7 -> m_en=m_we=1, m_addr=0x54, m_wdata=7, d_ready=1 in the same cycle; no d_rvalid; an i_req issued next cycle is granted immediately.
- Read granted, then reset pulled low during WAIT for 1 cycle -> all outputs 0, no i_rvalid or d_rvalid ever appears for that read; a following read of 0x40 completes normally with 3-cycle latency.
- i_req raised while D read is in WAIT, then dropped before RESP -> no I grant and no m_en for I; last_grant stays D.
- With MEM_PORT_ARBITER_PERF_EN defined, previous contention scenario -> i_stall_cnt=3 when I is granted; both counters read 0 after reset.
